ones_batch_accum: RTL and testbench

Downstream consumer of the ones-count hardware thread. It captures each bit-count result on the cycle it is announced and buffers it in a small FIFO, because the counter stage has no backpressure. Results are accumulated in batches of N words into a total, a maximum and a non-zero-word tally. Each batch summary is presented to the next stage under a valid/ack handshake.

---
 rtl/ones_batch_accum.sv | 167 ++++++++++++++++
 tb/tb_ones_batch_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ones_batch_accum.sv
// ones_batch_accum: buffers per-word ones counts from a non-backpressured
// producer in a small FIFO and folds them into N-word batch summaries
// (total, maximum, non-zero tally) offered under a valid/ack handshake.
module ones_batch_accum #(
   parameter int W     = 30,
   parameter int CW    = $clog2(W + 1),
   parameter int N     = 8,
   parameter int DEPTH = 4,
   parameter int SW    = $clog2(N * W + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       count_valid,
   input  logic [CW-1:0]              count,
   input  logic                       sum_ack,
   output logic                       sum_valid,
   output logic [SW-1:0]              sum,
   output logic [CW-1:0]              max_count,
   output logic [$clog2(N+1)-1:0]     nonzero,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                       overflow,
   output logic                       err
);

   localparam int NZW = $clog2(N + 1);
   localparam int LW  = $clog2(DEPTH + 1);
   // DEPTH is a power of two >= 2, so pointer arithmetic wraps modulo DEPTH.
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // idx only ever holds 0..N-1; the N-th pop clears it instead of storing N.
   localparam int IW  = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {ACC, HOLD} state_t;

   // FIFO storage and bookkeeping
   logic [CW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic          err_q, err_d;

   // Batch accumulator state
   state_t          state_q;
   logic [IW-1:0]   idx_q;
   logic [SW-1:0]   sum_q;
   logic [CW-1:0]   max_q;
   logic [NZW-1:0]  nz_q;
   logic            valid_q;

   logic          legal;
   logic          full;
   logic          pop;
   logic          push;
   logic [CW-1:0] head;

   // Push/pop decisions and next-state for pointers, level and sticky flags
   always_comb begin
      legal      = (count <= CW'(W));
      full       = (level_q == LW'(DEPTH));
      pop        = (state_q == ACC) && (level_q != '0);
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      push       = count_valid && legal && (!full || pop);
      head       = mem_q[rd_ptr_q];

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      err_d      = err_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
      if (count_valid && !legal) begin
         err_d = 1'b1;
      end
      if (count_valid && legal && full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   // FIFO data array: written on push, no reset needed for contents
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= count;
      end
   end

   // FIFO pointers, occupancy and sticky error flags
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         err_q      <= err_d;
      end
   end

   // Batch FSM: accumulate N popped counts, then hold the summary until acked
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ACC;
         idx_q   <= '0;
         sum_q   <= '0;
         max_q   <= '0;
         nz_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (pop) begin
                  sum_q <= sum_q + SW'(head);
                  if (head > max_q) begin
                     max_q <= head;
                  end
                  if (head != '0) begin
                     nz_q <= nz_q + NZW'(1);
                  end
                  if (idx_q == IW'(N - 1)) begin
                     idx_q   <= '0;
                     state_q <= HOLD;
                     valid_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
            HOLD: begin
               if (sum_ack) begin
                  sum_q   <= '0;
                  max_q   <= '0;
                  nz_q    <= '0;
                  valid_q <= 1'b0;
                  state_q <= ACC;
               end
            end
            default: begin
               state_q <= ACC;
            end
         endcase
      end
   end

   assign sum_valid  = valid_q;
   assign sum        = sum_q;
   assign max_count  = max_q;
   assign nonzero    = nz_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ones_batch_accum.sv
// Testbench for ones_batch_accum: table-driven single-batch and streaming
// vectors, then hand-written overflow, full-with-pop, illegal-count and
// mid-batch reset sequences.
module tb_ones_batch_accum;

   localparam int W     = 30;
   localparam int CW    = 5;
   localparam int N     = 8;
   localparam int DEPTH = 4;
   localparam int SW    = 8;
   localparam int NZW   = 4;
   localparam int LW    = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic            count_valid;
   logic [CW-1:0]   count;
   logic            sum_ack;
   logic            sum_valid;
   logic [SW-1:0]   sum;
   logic [CW-1:0]   max_count;
   logic [NZW-1:0]  nonzero;
   logic [LW-1:0]   fifo_level;
   logic            overflow;
   logic            err;

   ones_batch_accum #(.W(W), .CW(CW), .N(N), .DEPTH(DEPTH), .SW(SW)) dut (
      .clock       (clock),
      .reset       (reset),
      .count_valid (count_valid),
      .count       (count),
      .sum_ack     (sum_ack),
      .sum_valid   (sum_valid),
      .sum         (sum),
      .max_count   (max_count),
      .nonzero     (nonzero),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .err         (err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          cv;
      logic [CW-1:0] c;
      logic          ack;
      int            v;
      int            s;
      int            m;
      int            nz;
      int            lvl;
      int            ov;
      int            er;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void put(input logic cv, input int c, input logic ack,
                               input int v, input int s, input int m, input int nz,
                               input int lvl, input int ov, input int er);
      vec_t r;
      r.cv = cv; r.c = CW'(c); r.ack = ack;
      r.v = v; r.s = s; r.m = m; r.nz = nz; r.lvl = lvl; r.ov = ov; r.er = er;
      tbl.push_back(r);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input int v, input int s, input int m,
                          input int nz, input int lvl, input int ov, input int er);
      chk({tag, ".sum_valid"}, int'(sum_valid), v);
      chk({tag, ".sum"}, int'(sum), s);
      chk({tag, ".max_count"}, int'(max_count), m);
      chk({tag, ".nonzero"}, int'(nonzero), nz);
      chk({tag, ".fifo_level"}, int'(fifo_level), lvl);
      chk({tag, ".overflow"}, int'(overflow), ov);
      chk({tag, ".err"}, int'(err), er);
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic tick(input logic cv, input int c, input logic ack);
      count_valid = cv;
      count       = CW'(c);
      sum_ack     = ack;
      @(posedge clock);
      #1;
   endtask

   // One reset cycle; a count_valid pulse is offered during it and must be ignored.
   task automatic do_reset(input int c);
      reset = 1'b1;
      tick(1'b1, c, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; count_valid = 1'b0; count = '0; sum_ack = 1'b0;
      @(posedge clock); #1;
      do_reset(5);
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

      // Single batch: 3,0,5,30,1,0,2,7 with an idle cycle after each
      put(1, 3, 0, 0,  0,  0, 0, 1, 0, 0);
      put(0, 0, 0, 0,  3,  3, 1, 0, 0, 0);
      put(1, 0, 0, 0,  3,  3, 1, 1, 0, 0);
      put(0, 0, 0, 0,  3,  3, 1, 0, 0, 0);
      put(1, 5, 0, 0,  3,  3, 1, 1, 0, 0);
      put(0, 0, 0, 0,  8,  5, 2, 0, 0, 0);
      put(1, 30, 0, 0, 8,  5, 2, 1, 0, 0);
      put(0, 0, 0, 0,  38, 30, 3, 0, 0, 0);
      put(1, 1, 0, 0,  38, 30, 3, 1, 0, 0);
      put(0, 0, 0, 0,  39, 30, 4, 0, 0, 0);
      put(1, 0, 0, 0,  39, 30, 4, 1, 0, 0);
      put(0, 0, 0, 0,  39, 30, 4, 0, 0, 0);
      put(1, 2, 0, 0,  39, 30, 4, 1, 0, 0);
      put(0, 0, 0, 0,  41, 30, 5, 0, 0, 0);
      put(1, 7, 0, 0,  41, 30, 5, 1, 0, 0);
      put(0, 0, 0, 1,  48, 30, 6, 0, 0, 0);
      for (int k = 0; k < 10; k++) put(0, 0, 0, 1, 48, 30, 6, 0, 0, 0);
      put(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      // Streaming: 16 consecutive counts of 1, each summary acked on sight
      for (int k = 1; k <= 9; k++)
         put(1, 1, 0, (k == 9) ? 1 : 0, k - 1, (k > 1) ? 1 : 0, k - 1, 1, 0, 0);
      put(1, 1, 1, 0, 0, 0, 0, 2, 0, 0);
      for (int k = 1; k <= 6; k++) put(1, 1, 0, 0, k, 1, k, 2, 0, 0);
      put(0, 0, 0, 0, 7, 1, 7, 1, 0, 0);
      put(0, 0, 0, 1, 8, 1, 8, 0, 0, 0);
      put(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].cv, int'(tbl[i].c), tbl[i].ack);
         chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].s, tbl[i].m, tbl[i].nz,
                 tbl[i].lvl, tbl[i].ov, tbl[i].er);
      end

      // Overflow: hold a finished batch, push 5 counts of 2 into a 4-deep FIFO
      for (int i = 0; i < 8; i++) tick(1'b1, 1, 1'b0);
      tick(1'b0, 0, 1'b0);
      chk_all("ovf.batch", 1, 8, 1, 8, 0, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         tick(1'b1, 2, 1'b0);
         chk($sformatf("ovf.level%0d", i), int'(fifo_level), (i < 4) ? i : 4);
         chk($sformatf("ovf.flag%0d", i), int'(overflow), (i == 5) ? 1 : 0);
         chk($sformatf("ovf.held%0d", i), int'(sum), 8);
      end
      tick(1'b0, 0, 1'b1);
      chk_all("ovf.ack", 0, 0, 0, 0, 4, 1, 0);
      for (int i = 1; i <= 4; i++) begin
         tick(1'b0, 0, 1'b0);
         chk($sformatf("ovf.drain%0d", i), int'(sum), 2 * i);
      end
      for (int i = 0; i < 4; i++) tick(1'b1, 2, 1'b0);
      tick(1'b0, 0, 1'b0);
      chk_all("ovf.next", 1, 16, 2, 8, 0, 1, 0);
      tick(1'b0, 0, 1'b1);
      chk_all("ovf.ack2", 0, 0, 0, 0, 0, 1, 0);

      // Full FIFO in ACC with a simultaneous push of 9
      do_reset(3);
      chk_all("full.reset", 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) tick(1'b1, 1, 1'b0);
      tick(1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 3, 1'b0);
      chk_all("full.filled", 1, 8, 1, 8, 4, 0, 0);
      tick(1'b0, 0, 1'b1);
      chk_all("full.ack", 0, 0, 0, 0, 4, 0, 0);
      tick(1'b1, 9, 1'b0);
      chk_all("full.pushpop", 0, 3, 3, 1, 4, 0, 0);
      for (int i = 0; i < 4; i++) tick(1'b0, 0, 1'b0);
      chk_all("full.drained", 0, 21, 9, 5, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 0, 1'b0);
      tick(1'b0, 0, 1'b0);
      chk_all("full.batch", 1, 21, 9, 5, 0, 0, 0);
      tick(1'b0, 0, 1'b1);

      // Illegal count, then 8 legal counts (one with a stray ack in ACC)
      tick(1'b1, 31, 1'b0);
      chk_all("ill.drop", 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) tick(1'b1, 5, (i == 4) ? 1'b1 : 1'b0);
      chk_all("ill.stray_ack", 0, 35, 5, 7, 1, 0, 1);
      tick(1'b0, 0, 1'b0);
      chk_all("ill.batch", 1, 40, 5, 8, 0, 0, 1);
      tick(1'b0, 0, 1'b1);

      // Reset mid-batch discards the partial batch
      for (int i = 0; i < 3; i++) tick(1'b1, 7, 1'b0);
      chk_all("rst.partial", 0, 14, 7, 2, 1, 0, 1);
      do_reset(7);
      chk_all("rst.after", 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) tick(1'b1, 4, 1'b0);
      tick(1'b0, 0, 1'b0);
      chk_all("rst.batch", 1, 32, 4, 8, 0, 0, 0);
      tick(1'b0, 0, 1'b1);
      chk_all("rst.ack", 0, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
